// File: rtl/avalon_bus_arbiter_if.sv
// Avalon-MM master port bundle: the single memory-mapped bus shared by the
// fetch and load/store requesters of avalon_bus_arbiter.
interface avalon_bus_arbiter_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one Avalon-MM master with stall and
// optional wait timeout. Define ARB_ROUND_ROBIN_EN for alternating priority.
module avalon_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        reset_n_i,
    input  logic                        if_req_i,
    input  logic [31:0]                 if_addr_i,
    output logic                        if_gnt_o,
    output logic                        if_valid_o,
    output logic [31:0]                 if_rdata_o,
    input  logic                        data_req_i,
    input  logic                        data_we_i,
    input  logic [31:0]                 data_addr_i,
    input  logic [3:0]                  data_be_i,
    input  logic [31:0]                 data_wdata_i,
    output logic                        data_gnt_o,
    output logic                        data_valid_o,
    output logic [31:0]                 data_rdata_o,
    avalon_bus_arbiter_if.master        bus,
    output logic                        stall_o,
    output logic                        timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUS,
        DATA_BUS
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    // Saturates so a disabled timeout never wraps back into range.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t            state_q;
    logic [31:0]       addr_p1;
    logic [3:0]        be_p1;
    logic [31:0]       wdata_p1;
    logic              we_p1;
    logic              rd_p1;
    logic              wr_p1;
    logic [CNT_W-1:0]  wait_cnt_p1;
    logic [31:0]       if_rdata_p2;
    logic [31:0]       data_rdata_p2;
    logic              if_vld_p2;
    logic              data_vld_p2;
    logic              timeout_q;
    logic              pick_data;
    logic              timeout_hit;
    logic              addr_lsb_unused;

    // Byte-lane selection is carried by byteenable, so the address LSBs are dropped.
    assign addr_lsb_unused = ^{if_addr_i[1:0], data_addr_i[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;  // 1 = DATA was granted last, 0 = IF

    assign pick_data = data_req_i && (!if_req_i || !last_grant_q);

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_q <= 1'b0;
        end else if (data_gnt_o) begin
            last_grant_q <= 1'b1;
        end else if (if_gnt_o) begin
            last_grant_q <= 1'b0;
        end
    end
`else
    assign pick_data = data_req_i;
`endif

    always_comb begin
        if_gnt_o   = 1'b0;
        data_gnt_o = 1'b0;
        if (state_q == IDLE) begin
            data_gnt_o = pick_data;
            if_gnt_o   = if_req_i && !pick_data;
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt_p1 == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            addr_p1       <= '0;
            be_p1         <= '0;
            wdata_p1      <= '0;
            we_p1         <= 1'b0;
            rd_p1         <= 1'b0;
            wr_p1         <= 1'b0;
            wait_cnt_p1   <= '0;
            if_rdata_p2   <= '0;
            data_rdata_p2 <= '0;
            if_vld_p2     <= 1'b0;
            data_vld_p2   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            if_vld_p2   <= 1'b0;
            data_vld_p2 <= 1'b0;
            case (state_q)
                // p0 -> p1: latch the granted request into the bus registers
                IDLE: begin
                    wait_cnt_p1 <= '0;
                    if (data_gnt_o) begin
                        addr_p1  <= {data_addr_i[31:2], 2'b00};
                        be_p1    <= data_be_i;
                        wdata_p1 <= data_wdata_i;
                        we_p1    <= data_we_i;
                        rd_p1    <= !data_we_i;
                        wr_p1    <= data_we_i;
                        state_q  <= DATA_BUS;
                    end else if (if_gnt_o) begin
                        addr_p1  <= {if_addr_i[31:2], 2'b00};
                        be_p1    <= 4'hF;
                        we_p1    <= 1'b0;
                        rd_p1    <= 1'b1;
                        wr_p1    <= 1'b0;
                        state_q  <= IF_BUS;
                    end
                end
                // p1 -> p2: bus completes or times out; response registered
                IF_BUS, DATA_BUS: begin
                    if (!bus.waitrequest || timeout_hit) begin
                        rd_p1   <= 1'b0;
                        wr_p1   <= 1'b0;
                        state_q <= IDLE;
                        if (state_q == IF_BUS) begin
                            if_vld_p2 <= 1'b1;
                        end else begin
                            data_vld_p2 <= 1'b1;
                        end
                        if (bus.waitrequest) begin
                            timeout_q <= 1'b1;
                            if (state_q == IF_BUS) begin
                                if_rdata_p2 <= '0;
                            end else begin
                                data_rdata_p2 <= '0;
                            end
                        end else if (!we_p1) begin
                            if (state_q == IF_BUS) begin
                                if_rdata_p2 <= bus.readdata;
                            end else begin
                                data_rdata_p2 <= bus.readdata;
                            end
                        end
                    end else begin
                        wait_cnt_p1 <= sat_inc(wait_cnt_p1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.address    = addr_p1;
    assign bus.byteenable = be_p1;
    assign bus.writedata  = wdata_p1;
    assign bus.read       = rd_p1;
    assign bus.write      = wr_p1;

    assign if_valid_o   = if_vld_p2;
    assign if_rdata_o   = if_rdata_p2;
    assign data_valid_o = data_vld_p2;
    assign data_rdata_o = data_rdata_p2;
    assign timeout_o    = timeout_q;

    assign stall_o = (state_q != IDLE) || (if_req_i && !if_gnt_o) ||
                     (data_req_i && !data_gnt_o);

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Scoreboard bench for avalon_bus_arbiter: directed transactions, a bus slave
// model, and a monitor checking grants, bus cycles, responses and stall.
module tb_avalon_bus_arbiter;
    localparam int TO = 4;

    logic        clk;
    logic        reset_n_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_valid_o;
    logic [31:0] if_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_valid_o;
    logic [31:0] data_rdata_o;
    logic        stall_o;
    logic        timeout_o;

    avalon_bus_arbiter_if bus ();

    avalon_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_valid_o  (if_valid_o),
        .if_rdata_o  (if_rdata_o),
        .data_req_i  (data_req_i),
        .data_we_i   (data_we_i),
        .data_addr_i (data_addr_i),
        .data_be_i   (data_be_i),
        .data_wdata_i(data_wdata_i),
        .data_gnt_o  (data_gnt_o),
        .data_valid_o(data_valid_o),
        .data_rdata_o(data_rdata_o),
        .bus         (bus),
        .stall_o     (stall_o),
        .timeout_o   (timeout_o)
    );

    typedef struct {
        bit          port;   // 1 = DATA, 0 = IF
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          bus_cyc;
        bit          to;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   have_cur;
    bit   open;
    bit   exp_to;
    int   bus_n;
    int   cyc;
    int   gnt_cyc;
    int   last_bus_cyc;
    int   cfg_waits;
    int   n_checks;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h2402_0005;
            32'hBFC0_0004: return 32'h8FA2_0010;
            32'hBFC0_0008: return 32'h3C1D_BFC0;
            32'h0000_0104: return 32'h1122_3344;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Avalon slave: holds waitrequest for cfg_waits cycles of each access.
    initial begin : slave
        int busy;
        busy = 0;
        bus.waitrequest = 1'b0;
        bus.readdata    = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.read || bus.write) begin
                bus.waitrequest = (busy < cfg_waits);
                bus.readdata    = bus.read ? mem_rd(bus.address) : 32'hFFFF_FFFF;
                busy++;
            end else begin
                busy = 0;
                bus.waitrequest = 1'b0;
                bus.readdata    = 32'hE5E5_E5E5;
            end
        end
    end

    initial begin : monitor
        have_cur = 0;
        open     = 0;
        exp_to   = 0;
        bus_n    = 0;
        forever begin
            @(negedge clk);
            if (!reset_n_i) begin
                have_cur = 0;
                open     = 0;
                exp_to   = 0;
                bus_n    = 0;
                exp_q.delete();
                continue;
            end
            chk("stall", stall_o, (open && !(if_valid_o || data_valid_o)) ||
                (if_req_i && !if_gnt_o) || (data_req_i && !data_gnt_o));
            if (if_valid_o || data_valid_o) begin
                chk("valid_onehot", if_valid_o && data_valid_o, 0);
                if (!have_cur) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("valid_port", data_valid_o, cur.port);
                    chk("rdata", cur.port ? data_rdata_o : if_rdata_o, cur.rdata);
                    chk("bus_cycles", bus_n, cur.bus_cyc);
                    chk("valid_latency", cyc - last_bus_cyc, 1);
                    chk("bus_idle_at_valid", bus.read || bus.write, 0);
                    exp_to = exp_to | cur.to;
                    chk("timeout_flag", timeout_o, exp_to);
                    have_cur = 0;
                end
                open = 0;
            end
            if (bus.read || bus.write) begin
                chk("rw_exclusive", bus.read && bus.write, 0);
                if (!have_cur) begin
                    chk("bus_without_gnt", 1, 0);
                end else begin
                    if (bus_n == 0) chk("bus_latency", cyc - gnt_cyc, 1);
                    chk("address", bus.address, cur.addr);
                    chk("byteenable", bus.byteenable, cur.be);
                    chk("read", bus.read, !cur.we);
                    chk("write", bus.write, cur.we);
                    if (cur.we) chk("writedata", bus.writedata, cur.wdata);
                    bus_n++;
                    last_bus_cyc = cyc;
                end
            end
            if (if_gnt_o || data_gnt_o) begin
                chk("gnt_onehot", if_gnt_o && data_gnt_o, 0);
                if (have_cur || exp_q.size() == 0) begin
                    chk("unexpected_gnt", 1, 0);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1;
                    bus_n    = 0;
                    gnt_cyc  = cyc;
                    chk("gnt_port", data_gnt_o, cur.port);
                end
                open = 1;
            end
        end
    end

    task automatic push_exp(input bit port, input bit we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int bus_cyc, input bit to);
        txn_t t;
        t.port    = port;
        t.we      = we;
        t.addr    = addr;
        t.be      = be;
        t.wdata   = wdata;
        t.rdata   = rdata;
        t.bus_cyc = bus_cyc;
        t.to      = to;
        exp_q.push_back(t);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((have_cur || exp_q.size() != 0) && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 60) chk("completion_timeout", 1, 0);
    endtask

    task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata, input int waits,
                         input logic [31:0] exp_addr, input logic [31:0] exp_rdata,
                         input int exp_bus, input bit exp_to, input bit poke);
        int n = 0;
        cfg_waits = waits;
        push_exp(port, port ? we : 1'b0, exp_addr, port ? be : 4'hF, wdata,
                 exp_rdata, exp_bus, exp_to);
        @(posedge clk);
        #1;
        if (port) begin
            data_req_i   = 1'b1;
            data_we_i    = we;
            data_addr_i  = addr;
            data_be_i    = be;
            data_wdata_i = wdata;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = addr;
        end
        #1;
        while (!(port ? data_gnt_o : if_gnt_o) && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 20) chk("gnt_wait_timeout", 1, 0);
        @(posedge clk);
        #1;
        if_req_i   = 1'b0;
        data_req_i = 1'b0;
        // A request raised and dropped while the bus is busy must never be granted.
        if (poke) begin
            if_req_i  = 1'b1;
            if_addr_i = 32'hBFC0_0008;
            @(posedge clk);
            #1;
            if_req_i = 1'b0;
        end
        wait_quiet();
    endtask

    initial begin : stimulus
        bit gi, gd;
        int n, g;
        n_checks     = 0;
        n_fail       = 0;
        cfg_waits    = 0;
        reset_n_i    = 1'b0;
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_addr_i  = '0;
        data_be_i    = '0;
        data_wdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read", bus.read, 0);
        chk("rst_write", bus.write, 0);
        chk("rst_address", bus.address, 0);
        chk("rst_byteenable", bus.byteenable, 0);
        chk("rst_if_valid", if_valid_o, 0);
        chk("rst_data_valid", data_valid_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_stall", stall_o, 0);
        reset_n_i = 1'b1;

        // Fetch, zero wait
        issue(0, 0, 32'hBFC0_0000, 4'h0, 32'h0, 0, 32'hBFC0_0000, 32'h2402_0005, 1, 0, 0);
        // Unaligned data read, one wait
        issue(1, 0, 32'h0000_0106, 4'hF, 32'h0, 1, 32'h0000_0104, 32'h1122_3344, 2, 0, 0);
        // Write with three waits; rdata keeps the previous read value
        issue(1, 1, 32'h0000_1003, 4'b1000, 32'hAABB_CCDD, 3, 32'h0000_1000,
              32'h1122_3344, 4, 0, 1);
        // Fetch, two waits
        issue(0, 0, 32'hBFC0_0004, 4'h0, 32'h0, 2, 32'hBFC0_0004, 32'h8FA2_0010, 3, 0, 0);
        // Timeout: waitrequest stuck
        issue(1, 0, 32'h0000_2000, 4'hF, 32'h0, 100, 32'h0000_2000, 32'h0, TO, 1, 0);
        chk("timeout_set", timeout_o, 1);
        // Normal fetch after timeout; flag stays set
        issue(0, 0, 32'hBFC0_0008, 4'h0, 32'h0, 0, 32'hBFC0_0008, 32'h3C1D_BFC0, 1, 0, 0);
        chk("timeout_sticky", timeout_o, 1);

        // Reset mid-transfer
        cfg_waits = 10;
        push_exp(1, 0, 32'h0000_0104, 4'hF, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        data_req_i  = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h0000_0104;
        data_be_i   = 4'hF;
        #1;
        n = 0;
        while (!data_gnt_o && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 20) chk("gnt_wait_timeout", 1, 0);
        @(posedge clk);
        #1;
        data_req_i = 1'b0;
        @(posedge clk);
        #3;
        chk("read_before_reset", bus.read, 1);
        reset_n_i = 1'b0;
        #1;
        chk("arst_read", bus.read, 0);
        chk("arst_write", bus.write, 0);
        chk("arst_address", bus.address, 0);
        chk("arst_writedata", bus.writedata, 0);
        chk("arst_timeout", timeout_o, 0);
        chk("arst_data_rdata", data_rdata_o, 0);
        chk("arst_if_rdata", if_rdata_o, 0);
        repeat (2) @(posedge clk);
        #1;
        cfg_waits = 0;
        reset_n_i = 1'b1;
        #1;
        chk("post_rst_stall", stall_o, 0);
        chk("post_rst_gnt", if_gnt_o || data_gnt_o, 0);

        // Simultaneous requests, each dropped after its own grant
        push_exp(1, 0, 32'h0000_0104, 4'hF, 32'h0, 32'h1122_3344, 1, 0);
        push_exp(0, 0, 32'hBFC0_0000, 4'hF, 32'h0, 32'h2402_0005, 1, 0);
        @(posedge clk);
        #1;
        data_req_i  = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h0000_0104;
        data_be_i   = 4'hF;
        if_req_i    = 1'b1;
        if_addr_i   = 32'hBFC0_0000;
        #1;
        n = 0;
        while ((if_req_i || data_req_i) && n < 40) begin
            gi = if_gnt_o;
            gd = data_gnt_o;
            @(posedge clk);
            #1;
            if (gd) data_req_i = 1'b0;
            if (gi) if_req_i = 1'b0;
            #1;
            n++;
        end
        if (n >= 40) chk("simul_grant_timeout", 1, 0);
        wait_quiet();

        // Both requests held for four grants
`ifdef ARB_ROUND_ROBIN_EN
        push_exp(1, 0, 32'h0000_0104, 4'hF, 32'h0, 32'h1122_3344, 1, 0);
        push_exp(0, 0, 32'hBFC0_0004, 4'hF, 32'h0, 32'h8FA2_0010, 1, 0);
        push_exp(1, 0, 32'h0000_0104, 4'hF, 32'h0, 32'h1122_3344, 1, 0);
        push_exp(0, 0, 32'hBFC0_0004, 4'hF, 32'h0, 32'h8FA2_0010, 1, 0);
`else
        for (int k = 0; k < 4; k++) begin
            push_exp(1, 0, 32'h0000_0104, 4'hF, 32'h0, 32'h1122_3344, 1, 0);
        end
`endif
        @(posedge clk);
        #1;
        data_req_i = 1'b1;
        if_req_i   = 1'b1;
        if_addr_i  = 32'hBFC0_0004;
        #1;
        n = 0;
        g = 0;
        while (n < 40) begin
            if (if_gnt_o || data_gnt_o) g++;
            if (g == 4) break;
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 40) chk("hold_grant_timeout", 1, 0);
        @(posedge clk);
        #1;
        data_req_i = 1'b0;
        if_req_i   = 1'b0;
        wait_quiet();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
